// File: rtl/digdug_hvgen.sv
// Raster timing generator for the DigDug video pipeline: divides the 48 MHz
// master clock into the pixel cadence, runs the POSH/POSV raster counters and
// produces blanking/sync (aligned and pipeline-delayed) plus CPU strobes.
`timescale 1ns/1ps
module digdug_hvgen #(
    parameter int H_FIRST     = 128,
    parameter int H_LAST      = 511,
    parameter int V_LAST      = 263,
    parameter int HACT_START  = 136,
    parameter int HACT_END    = 424,
    parameter int HSYNC_START = 448,
    parameter int HSYNC_END   = 480,
    parameter int VACT_END    = 224,
    parameter int VSYNC_START = 240,
    parameter int VSYNC_END   = 244,
    parameter int PIPE_DLY    = 3
) (
    input  logic       CLK48M,
    input  logic       RESET,
    output logic       PCE,
    output logic [8:0] POSH,
    output logic [8:0] POSV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HSYN,
    output logic       VSYN,
    output logic       HBLK_D,
    output logic       VBLK_D,
    output logic       HSYN_D,
    output logic       VSYN_D,
    output logic       LSTRB,
    output logic       VBIRQ,
    output logic       FRAME
);

    localparam logic [8:0] H_FIRST_V     = 9'(H_FIRST);
    localparam logic [8:0] H_LAST_V      = 9'(H_LAST);
    localparam logic [8:0] V_LAST_V      = 9'(V_LAST);
    localparam logic [8:0] HACT_START_V  = 9'(HACT_START);
    localparam logic [8:0] HACT_END_V    = 9'(HACT_END);
    localparam logic [8:0] HSYNC_START_V = 9'(HSYNC_START);
    localparam logic [8:0] HSYNC_END_V   = 9'(HSYNC_END);
    localparam logic [8:0] VACT_END_V    = 9'(VACT_END);
    localparam logic [8:0] VSYNC_START_V = 9'(VSYNC_START);
    localparam logic [8:0] VSYNC_END_V   = 9'(VSYNC_END);
    // Line whose end leads into the first vertically blanked line.
    localparam logic [8:0] VBIRQ_LINE_V  = 9'(VACT_END - 1);

    // Flag bundle order: {hblk, vblk, hsyn, vsyn}.
    function automatic logic [3:0] decode(input logic [8:0] h, input logic [8:0] v);
        logic hblk;
        logic vblk;
        logic hsyn;
        logic vsyn;
        hblk = (h < HACT_START_V) || (h >= HACT_END_V);
        vblk = (v >= VACT_END_V);
        hsyn = (h >= HSYNC_START_V) && (h < HSYNC_END_V);
        vsyn = (v >= VSYNC_START_V) && (v < VSYNC_END_V);
        return {hblk, vblk, hsyn, vsyn};
    endfunction

    localparam logic [3:0] RST_FLAGS = decode(H_FIRST_V, 9'd0);

    logic [2:0] div_r;
    logic [8:0] h_r;
    logic [8:0] v_r;
    logic [8:0] h_nxt_s;
    logic [8:0] v_nxt_s;
    logic       pce_s;
    logic       line_end_s;
    logic [3:0] flags_r;
    logic [3:0] dly_r [PIPE_DLY];
    logic       lstrb_r;
    logic       vbirq_r;
    logic       frame_r;

    assign pce_s = (div_r == 3'd7);

    // Next raster position: advance one pixel per PCE, wrapping line and frame.
    always_comb begin
        line_end_s = 1'b0;
        h_nxt_s    = h_r;
        v_nxt_s    = v_r;
        if (pce_s) begin
            if (h_r == H_LAST_V) begin
                line_end_s = 1'b1;
                h_nxt_s    = H_FIRST_V;
                if (v_r == V_LAST_V) begin
                    v_nxt_s = 9'd0;
                end else begin
                    v_nxt_s = v_r + 9'd1;
                end
            end else begin
                h_nxt_s = h_r + 9'd1;
            end
        end else begin
            h_nxt_s = h_r;
        end
    end

    // Pixel divider and raster counters.
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            div_r <= 3'd0;
            h_r   <= H_FIRST_V;
            v_r   <= 9'd0;
        end else begin
            div_r <= div_r + 3'd1;
            h_r   <= h_nxt_s;
            v_r   <= v_nxt_s;
        end
    end

    // Aligned flags decoded from the next position so they never lag the counters.
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            flags_r <= RST_FLAGS;
        end else begin
            flags_r <= decode(h_nxt_s, v_nxt_s);
        end
    end

    // Pixel-rate delay line lining the flags up with the palette output.
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                dly_r[i] <= RST_FLAGS;
            end
        end else if (pce_s) begin
            dly_r[0] <= flags_r;
            for (int i = 1; i < PIPE_DLY; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    // Line-start and VBLANK strobes plus the frame parity toggle.
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            lstrb_r <= 1'b0;
            vbirq_r <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            lstrb_r <= line_end_s;
            vbirq_r <= line_end_s && (v_r == VBIRQ_LINE_V);
            if (line_end_s && (v_r == V_LAST_V)) begin
                frame_r <= ~frame_r;
            end
        end
    end

    assign PCE    = pce_s;
    assign POSH   = h_r;
    assign POSV   = v_r;
    assign HBLK   = flags_r[3];
    assign VBLK   = flags_r[2];
    assign HSYN   = flags_r[1];
    assign VSYN   = flags_r[0];
    assign HBLK_D = dly_r[PIPE_DLY-1][3];
    assign VBLK_D = dly_r[PIPE_DLY-1][2];
    assign HSYN_D = dly_r[PIPE_DLY-1][1];
    assign VSYN_D = dly_r[PIPE_DLY-1][0];
    assign LSTRB  = lstrb_r;
    assign VBIRQ  = vbirq_r;
    assign FRAME  = frame_r;

endmodule

// File: tb/tb_digdug_hvgen.sv
// Bench for digdug_hvgen: a full-size instance and a shrunken-raster instance
// (PIPE_DLY = 1) so whole frames fit in a short run; every cycle is compared
// with a position-from-elapsed-time reference model.
`timescale 1ns/1ps
module tb_digdug_hvgen;

    logic clk_s = 1'b0;
    logic rst0_s;
    logic rst1_s;
    int   c0;
    int   c1;
    int   total = 0;
    int   bad = 0;

    logic pce0, hb0, vb0, hs0, vs0, hbd0, vbd0, hsd0, vsd0, ls0, vi0, fr0;
    logic pce1, hb1, vb1, hs1, vs1, hbd1, vbd1, hsd1, vsd1, ls1, vi1, fr1;
    logic [8:0] ph0, pv0, ph1, pv1;
    logic [29:0] obs0;
    logic [29:0] obs1;

    assign obs0 = {pce0, ph0, pv0, hb0, vb0, hs0, vs0, hbd0, vbd0, hsd0, vsd0, ls0, vi0, fr0};
    assign obs1 = {pce1, ph1, pv1, hb1, vb1, hs1, vs1, hbd1, vbd1, hsd1, vsd1, ls1, vi1, fr1};

    always #5 clk_s = ~clk_s;

    digdug_hvgen dut0 (
        .CLK48M(clk_s), .RESET(rst0_s), .PCE(pce0), .POSH(ph0), .POSV(pv0),
        .HBLK(hb0), .VBLK(vb0), .HSYN(hs0), .VSYN(vs0),
        .HBLK_D(hbd0), .VBLK_D(vbd0), .HSYN_D(hsd0), .VSYN_D(vsd0),
        .LSTRB(ls0), .VBIRQ(vi0), .FRAME(fr0)
    );

    digdug_hvgen #(
        .H_FIRST(8), .H_LAST(31), .V_LAST(19), .HACT_START(10), .HACT_END(26),
        .HSYNC_START(27), .HSYNC_END(30), .VACT_END(14), .VSYNC_START(16),
        .VSYNC_END(18), .PIPE_DLY(1)
    ) dut1 (
        .CLK48M(clk_s), .RESET(rst1_s), .PCE(pce1), .POSH(ph1), .POSV(pv1),
        .HBLK(hb1), .VBLK(vb1), .HSYN(hs1), .VSYN(vs1),
        .HBLK_D(hbd1), .VBLK_D(vbd1), .HSYN_D(hsd1), .VSYN_D(vsd1),
        .LSTRB(ls1), .VBIRQ(vi1), .FRAME(fr1)
    );

    // Expected outputs c clock edges after reset release: the pixel index is
    // c/8, and position, frame parity and strobes follow by plain arithmetic.
    function automatic logic [29:0] model(input int c, input int hf, input int hl,
                                          input int vl, input int has, input int hae,
                                          input int hss, input int hse, input int vae,
                                          input int vss, input int vse, input int dly);
        int line, p, pd, h, v, li, hd, vd;
        logic pce, ls, vi, fr;
        logic [3:0] fa, fd;
        line = hl - hf + 1;
        p    = c / 8;
        pce  = ((c % 8) == 7);
        h    = hf + p % line;
        li   = p / line;
        v    = li % (vl + 1);
        fr   = (((li / (vl + 1)) % 2) == 1);
        pd   = (p >= dly) ? p - dly : 0;
        hd   = hf + pd % line;
        vd   = (pd / line) % (vl + 1);
        fa   = {(h < has) || (h >= hae), v >= vae, (h >= hss) && (h < hse), (v >= vss) && (v < vse)};
        fd   = {(hd < has) || (hd >= hae), vd >= vae, (hd >= hss) && (hd < hse), (vd >= vss) && (vd < vse)};
        ls   = (c > 0) && ((c % 8) == 0) && ((p % line) == 0);
        vi   = ls && (v == vae);
        return {pce, 9'(h), 9'(v), fa, fd, ls, vi, fr};
    endfunction

    function automatic logic [29:0] exp0(input int c);
        return model(c, 128, 511, 263, 136, 424, 448, 480, 224, 240, 244, 3);
    endfunction

    function automatic logic [29:0] exp1(input int c);
        return model(c, 8, 31, 19, 10, 26, 27, 30, 14, 16, 18, 1);
    endfunction

    // Advance one clock; the edge counters restart at zero on every reset edge.
    task automatic step();
        @(posedge clk_s);
        c0 = rst0_s ? 0 : c0 + 1;
        c1 = rst1_s ? 0 : c1 + 1;
        #1;
    endtask

    task automatic test_reset();
        int first_pce;
        int second_pce;
        rst0_s = 1'b1;
        rst1_s = 1'b1;
        c0 = 0;
        c1 = 0;
        repeat (5) step();
        total++; if (obs0 !== exp0(0)) begin bad++; $display("FAIL reset_state0 got=%h want=%h", obs0, exp0(0)); end
        total++; if (obs1 !== exp1(0)) begin bad++; $display("FAIL reset_state1 got=%h want=%h", obs1, exp1(0)); end
        total++; if (ph0 !== 9'd128 || pv0 !== 9'd0 || hb0 !== 1'b1 || hbd0 !== 1'b1)
            begin bad++; $display("FAIL reset_pos posh=%0d posv=%0d hblk=%b hblk_d=%b want 128 0 1 1", ph0, pv0, hb0, hbd0); end
        rst0_s = 1'b0;
        rst1_s = 1'b0;
        first_pce = -1;
        second_pce = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            total++; if (obs0 !== exp0(c0)) begin bad++; $display("FAIL div0 c=%0d got=%h want=%h", c0, obs0, exp0(c0)); end
            total++; if (obs1 !== exp1(c1)) begin bad++; $display("FAIL div1 c=%0d got=%h want=%h", c1, obs1, exp1(c1)); end
            if (pce0 === 1'b1) begin
                if (first_pce < 0) first_pce = c0;
                else if (second_pce < 0) second_pce = c0;
            end
        end
        total++; if (first_pce != 7) begin bad++; $display("FAIL first_pce edge=%0d want=7", first_pce); end
        total++; if (second_pce - first_pce != 8) begin bad++; $display("FAIL pce_period got=%0d want=8", second_pce - first_pce); end
    endtask

    task automatic test_line();
        int lstrb_cnt = 0, hsyn_cyc = 0, hact_cyc = 0, hb_fall = -1, hbd_fall = -1;
        logic hb_prev, hbd_prev;
        hb_prev = hb0;
        hbd_prev = hbd0;
        while (c0 < 3080) begin
            step();
            total++; if (obs0 !== exp0(c0)) begin bad++; $display("FAIL line0 c=%0d got=%h want=%h", c0, obs0, exp0(c0)); end
            total++; if (obs1 !== exp1(c1)) begin bad++; $display("FAIL line1 c=%0d got=%h want=%h", c1, obs1, exp1(c1)); end
            if (ls0 === 1'b1) lstrb_cnt++;
            if (hs0 === 1'b1) hsyn_cyc++;
            if (hb0 === 1'b0) hact_cyc++;
            if (hb_prev === 1'b1 && hb0 === 1'b0 && hb_fall < 0) hb_fall = c0;
            if (hbd_prev === 1'b1 && hbd0 === 1'b0 && hbd_fall < 0) hbd_fall = c0;
            hb_prev = hb0;
            hbd_prev = hbd0;
            if (c0 == 3072) begin
                total++; if (ph0 !== 9'd128 || ls0 !== 1'b1 || pv0 !== 9'd1)
                    begin bad++; $display("FAIL line_wrap posh=%0d posv=%0d lstrb=%b want 128 1 1", ph0, pv0, ls0); end
            end
        end
        total++; if (lstrb_cnt != 1) begin bad++; $display("FAIL lstrb_count got=%0d want=1", lstrb_cnt); end
        total++; if (hsyn_cyc != 256) begin bad++; $display("FAIL hsyn_width got=%0d want=256", hsyn_cyc); end
        total++; if (hact_cyc != 2304) begin bad++; $display("FAIL hactive_width got=%0d want=2304", hact_cyc); end
        total++; if (hbd_fall - hb_fall != 24) begin bad++; $display("FAIL hblk_d_lag3 got=%0d want=24", hbd_fall - hb_fall); end
    endtask

    task automatic test_delay();
        int hb_fall = -1, hbd_fall = -1, hs_rise = -1, hsd_rise = -1;
        logic hb_p, hbd_p, hs_p, hsd_p;
        rst1_s = 1'b1;
        step();
        rst1_s = 1'b0;
        hb_p = hb1; hbd_p = hbd1; hs_p = hs1; hsd_p = hsd1;
        repeat (300) begin
            step();
            total++; if (obs0 !== exp0(c0)) begin bad++; $display("FAIL dly0 c=%0d got=%h want=%h", c0, obs0, exp0(c0)); end
            total++; if (obs1 !== exp1(c1)) begin bad++; $display("FAIL dly1 c=%0d got=%h want=%h", c1, obs1, exp1(c1)); end
            if (hb_p === 1'b1 && hb1 === 1'b0 && hb_fall < 0) hb_fall = c1;
            if (hbd_p === 1'b1 && hbd1 === 1'b0 && hbd_fall < 0) hbd_fall = c1;
            if (hs_p === 1'b0 && hs1 === 1'b1 && hs_rise < 0) hs_rise = c1;
            if (hsd_p === 1'b0 && hsd1 === 1'b1 && hsd_rise < 0) hsd_rise = c1;
            hb_p = hb1; hbd_p = hbd1; hs_p = hs1; hsd_p = hsd1;
        end
        total++; if (hb_fall < 0 || hbd_fall - hb_fall != 8) begin bad++; $display("FAIL hblk_d_lag1 got=%0d want=8", hbd_fall - hb_fall); end
        total++; if (hs_rise < 0 || hsd_rise - hs_rise != 8) begin bad++; $display("FAIL hsyn_d_lag1 got=%0d want=8", hsd_rise - hs_rise); end
    endtask

    task automatic test_frames();
        int vbirq_cnt = 0, frame_tog = 0;
        logic fr_prev;
        rst1_s = 1'b1;
        step();
        rst1_s = 1'b0;
        fr_prev = fr1;
        while (c1 < 3 * 3840 + 16) begin
            step();
            total++; if (obs0 !== exp0(c0)) begin bad++; $display("FAIL frm0 c=%0d got=%h want=%h", c0, obs0, exp0(c0)); end
            total++; if (obs1 !== exp1(c1)) begin bad++; $display("FAIL frm1 c=%0d got=%h want=%h", c1, obs1, exp1(c1)); end
            if (vi1 === 1'b1) begin
                vbirq_cnt++;
                total++; if (pv1 !== 9'd14 || ph1 !== 9'd8)
                    begin bad++; $display("FAIL vbirq_pos posv=%0d posh=%0d want 14 8", pv1, ph1); end
            end
            if (fr1 !== fr_prev) begin
                frame_tog++;
                total++; if (pv1 !== 9'd0 || ph1 !== 9'd8)
                    begin bad++; $display("FAIL frame_pos posv=%0d posh=%0d want 0 8", pv1, ph1); end
            end
            fr_prev = fr1;
        end
        total++; if (vbirq_cnt != 3) begin bad++; $display("FAIL vbirq_count got=%0d want=3", vbirq_cnt); end
        total++; if (frame_tog != 3) begin bad++; $display("FAIL frame_toggles got=%0d want=3", frame_tog); end
    endtask

    task automatic test_mid_reset();
        int lstrb_cnt = 0;
        int budget = 0;
        while (!(pce0 === 1'b1 && ph0 === 9'd300) && budget < 4000) begin
            step();
            budget++;
            total++; if (obs0 !== exp0(c0)) begin bad++; $display("FAIL seek0 c=%0d got=%h want=%h", c0, obs0, exp0(c0)); end
        end
        total++; if (budget >= 4000) begin bad++; $display("FAIL seek_posh300 got=timeout want=found"); end
        rst0_s = 1'b1;
        step();
        rst0_s = 1'b0;
        total++; if (obs0 !== exp0(0) || ls0 !== 1'b0 || vi0 !== 1'b0)
            begin bad++; $display("FAIL midreset_state got=%h want=%h", obs0, exp0(0)); end
        while (c0 < 3080) begin
            step();
            total++; if (obs0 !== exp0(c0)) begin bad++; $display("FAIL mid0 c=%0d got=%h want=%h", c0, obs0, exp0(c0)); end
            if (ls0 === 1'b1) lstrb_cnt++;
            if (c0 == 3072) begin
                total++; if (ph0 !== 9'd128 || ls0 !== 1'b1)
                    begin bad++; $display("FAIL mid_wrap posh=%0d lstrb=%b want 128 1", ph0, ls0); end
            end
        end
        total++; if (lstrb_cnt != 1) begin bad++; $display("FAIL mid_lstrb_count got=%0d want=1", lstrb_cnt); end
    endtask

    task automatic test_random_reset();
        for (int it = 0; it < 6; it++) begin
            int n;
            int len;
            n = int'($urandom_range(50, 3000));
            repeat (n) begin
                step();
                total++; if (obs0 !== exp0(c0)) begin bad++; $display("FAIL rnd0 c=%0d got=%h want=%h", c0, obs0, exp0(c0)); end
                total++; if (obs1 !== exp1(c1)) begin bad++; $display("FAIL rnd1 c=%0d got=%h want=%h", c1, obs1, exp1(c1)); end
            end
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8 && pce0 !== 1'b1; k++) step();
            end
            len = int'($urandom_range(1, 3));
            rst0_s = 1'b1;
            rst1_s = ($urandom_range(0, 1) == 1);
            repeat (len) begin
                step();
                total++; if (obs0 !== exp0(c0)) begin bad++; $display("FAIL rrst0 c=%0d got=%h want=%h", c0, obs0, exp0(c0)); end
                total++; if (obs1 !== exp1(c1)) begin bad++; $display("FAIL rrst1 c=%0d got=%h want=%h", c1, obs1, exp1(c1)); end
            end
            rst0_s = 1'b0;
            rst1_s = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_delay();
        test_frames();
        test_mid_reset();
        test_random_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
